// File: rtl/wb_mon_pkg.sv
// Shared types and error indices for the Wishbone slave protocol monitor.
package wb_mon_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int unsigned ERR_N        = 7;
  localparam int unsigned ERR_SPURIOUS = 0;
  localparam int unsigned ERR_DROP     = 1;
  localparam int unsigned ERR_UNSTABLE = 2;
  localparam int unsigned ERR_EARLY    = 3;
  localparam int unsigned ERR_LATE     = 4;
  localparam int unsigned ERR_TIMEOUT  = 5;
  localparam int unsigned ERR_ACK_LONG = 6;

endpackage

// File: rtl/wb_mon_err_log.sv
// Sticky error flags, one-cycle error pulse and first-error capture.
module wb_mon_err_log #(
  parameter int unsigned ERR_N = 7,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [ERR_N-1:0] set_i,
  output logic [ERR_N-1:0] err_o,
  output logic             pulse_o,
  output logic             vld_o,
  output logic [IDX_W-1:0] first_o
);

  logic [ERR_N-1:0] flags_q, flags_d, flags_base;
  logic             pulse_q, pulse_d;
  logic             vld_q, vld_d, vld_base;
  logic [IDX_W-1:0] first_q, first_d, first_base;
  logic             found;

  // Clear is applied before this cycle's new errors are merged in.
  always_comb begin
    flags_base = clr_i ? '0 : flags_q;
    vld_base   = clr_i ? 1'b0 : vld_q;
    first_base = clr_i ? '0 : first_q;
    flags_d    = flags_base | set_i;
    pulse_d    = |set_i;
    vld_d      = vld_base;
    first_d    = first_base;
    found      = 1'b0;
    if (!vld_base && (|set_i)) begin
      vld_d = 1'b1;
      for (int unsigned i = 0; i < ERR_N; i++) begin
        if (set_i[i] && !found) begin
          first_d = IDX_W'(i);
          found   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      pulse_q <= 1'b0;
      vld_q   <= 1'b0;
      first_q <= '0;
    end else begin
      flags_q <= flags_d;
      pulse_q <= pulse_d;
      vld_q   <= vld_d;
      first_q <= first_d;
    end
  end

  assign err_o   = flags_q;
  assign pulse_o = pulse_q;
  assign vld_o   = vld_q;
  assign first_o = first_q;

endmodule

// File: rtl/wb_slave_protocol_monitor.sv
// Passive Wishbone classic-slave monitor: ack latency window, request
// stability, single-cycle ack, timeout and completed-transaction count.
module wb_slave_protocol_monitor
  import wb_mon_pkg::*;
#(
  parameter int unsigned AW      = 3,
  parameter int unsigned DW      = 8,
  parameter int unsigned MIN_LAT = 1,
  parameter int unsigned MAX_LAT = 2,
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             wb_clk_i,
  input  logic             arst_i,
  input  logic [AW-1:0]    wb_adr_i,
  input  logic [DW-1:0]    wb_dat_i,
  input  logic             wb_we_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  input  logic             wb_ack_o,
  input  logic             clr_i,
  output logic [6:0]       err_o,
  output logic             err_pulse_o,
  output logic             first_err_vld_o,
  output logic [2:0]       first_err_o,
  output logic [CNT_W-1:0] txn_cnt_o,
  output logic             busy_o
);

  localparam int unsigned LAT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d, lat_now;
  logic [AW-1:0]      adr_q, adr_d;
  logic [DW-1:0]      dat_q, dat_d;
  logic               we_q, we_d;
  logic               unst_q, unst_d;
  logic               ackd_q, ackd_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
  logic               req, inc, mismatch;
  logic [ERR_N-1:0]   err_set;

  assign req      = wb_cyc_i & wb_stb_i;
  assign lat_now  = (lat_q == LAT_W'(TIMEOUT)) ? lat_q : lat_q + 1'b1;
  assign mismatch = (wb_adr_i != adr_q) || (wb_we_i != we_q) ||
                    (wb_we_i && (wb_dat_i != dat_q));

  // An ack directly after a counted ack is ACK_LONG; it neither counts nor
  // re-arms ackd, and takes precedence over a zero-latency request.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    unst_d  = unst_q;
    ackd_d  = 1'b0;
    inc     = 1'b0;
    err_set = '0;
    case (state_q)
      IDLE: begin
        if (wb_ack_o) begin
          if (ackd_q) begin
            err_set[ERR_ACK_LONG] = 1'b1;
          end else if (req) begin
            err_set[ERR_EARLY] = 1'b1;
            inc    = 1'b1;
            ackd_d = 1'b1;
          end else begin
            err_set[ERR_SPURIOUS] = 1'b1;
          end
        end else if (req) begin
          adr_d   = wb_adr_i;
          dat_d   = wb_dat_i;
          we_d    = wb_we_i;
          lat_d   = '0;
          unst_d  = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        lat_d = lat_now;
        if (!req) begin
          err_set[ERR_DROP] = 1'b1;
          state_d = IDLE;
        end else begin
          if (!unst_q && mismatch) begin
            err_set[ERR_UNSTABLE] = 1'b1;
            unst_d = 1'b1;
          end
          if (wb_ack_o) begin
            if (lat_now < LAT_W'(MIN_LAT)) err_set[ERR_EARLY] = 1'b1;
            if (lat_now > LAT_W'(MAX_LAT)) err_set[ERR_LATE]  = 1'b1;
            inc     = 1'b1;
            ackd_d  = 1'b1;
            state_d = IDLE;
          end else if (lat_now == LAT_W'(TIMEOUT)) begin
            err_set[ERR_TIMEOUT] = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    cnt_base = clr_i ? '0 : cnt_q;
    cnt_d    = (inc && (cnt_base != '1)) ? cnt_base + 1'b1 : cnt_base;
    busy_d   = (state_d == WAIT);
  end

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= IDLE;
      lat_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      unst_q  <= 1'b0;
      ackd_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      unst_q  <= unst_d;
      ackd_q  <= ackd_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  wb_mon_err_log #(
    .ERR_N (ERR_N),
    .IDX_W (3)
  ) u_err_log (
    .clk     (wb_clk_i),
    .rst_n   (arst_i),
    .clr_i   (clr_i),
    .set_i   (err_set),
    .err_o   (err_o),
    .pulse_o (err_pulse_o),
    .vld_o   (first_err_vld_o),
    .first_o (first_err_o)
  );

  assign txn_cnt_o = cnt_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_wb_slave_protocol_monitor.sv
// Scoreboard bench for wb_slave_protocol_monitor (CNT_W=2 to reach saturation).
module tb_wb_slave_protocol_monitor;

  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic [AW-1:0]    adr = '0;
  logic [DW-1:0]    dat = '0;
  logic             we = 1'b0, stb = 1'b0, cyc = 1'b0, ack = 1'b0, clr = 1'b0;
  logic [6:0]       err;
  logic             pulse, fvld, busy;
  logic [2:0]       first;
  logic [CNT_W-1:0] cnt;

  typedef struct packed {
    logic [6:0]       err;
    logic             vld;
    logic [2:0]       first;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  wb_slave_protocol_monitor #(
    .AW      (AW),
    .DW      (DW),
    .MIN_LAT (1),
    .MAX_LAT (2),
    .TIMEOUT (32),
    .CNT_W   (CNT_W)
  ) dut (
    .wb_clk_i        (clk),
    .arst_i          (arst_n),
    .wb_adr_i        (adr),
    .wb_dat_i        (dat),
    .wb_we_i         (we),
    .wb_stb_i        (stb),
    .wb_cyc_i        (cyc),
    .wb_ack_o        (ack),
    .clr_i           (clr),
    .err_o           (err),
    .err_pulse_o     (pulse),
    .first_err_vld_o (fvld),
    .first_err_o     (first),
    .txn_cnt_o       (cnt),
    .busy_o          (busy)
  );

  function automatic obs_t observe();
    obs_t o;
    o.err = err; o.vld = fvld; o.first = first; o.cnt = cnt;
    return o;
  endfunction

  task automatic push_exp(input string n, input logic [6:0] e, input logic v,
                          input logic [2:0] f, input logic [CNT_W-1:0] c);
    obs_t o;
    o.err = e; o.vld = v; o.first = f; o.cnt = c;
    exp_q.push_back(o);
    name_q.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; ack = 1'b0; clr = 1'b0;
  endtask

  task automatic clear();
    idle_bus();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Request held stable, ack in the cycle at latency lat, then one idle cycle.
  task automatic do_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                        input int lat, output int busy_cnt, output int pulse_cnt);
    busy_cnt = 0; pulse_cnt = 0;
    adr = a; dat = d; we = w; cyc = 1'b1; stb = 1'b1; ack = (lat == 0);
    tick();
    busy_cnt += int'(busy); pulse_cnt += int'(pulse);
    for (int i = 1; i <= lat; i++) begin
      ack = (i == lat);
      tick();
      busy_cnt += int'(busy); pulse_cnt += int'(pulse);
    end
    idle_bus();
    tick();
    busy_cnt += int'(busy); pulse_cnt += int'(pulse);
  endtask

  task automatic test_reset();
    obs_t e, a;
    string n;
    #2;
    push_exp("reset_state", 7'h00, 1'b0, 3'd0, '0);
    e = exp_q.pop_front(); n = name_q.pop_front(); a = observe();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got err=%h vld=%b first=%0d cnt=%0d, expected err=%h vld=%b first=%0d cnt=%0d",
               n, a.err, a.vld, a.first, a.cnt, e.err, e.vld, e.first, e.cnt);
    end
    checks++;
    if ({busy, pulse} !== 2'b00) begin
      errors++;
      $display("FAIL reset_busy_pulse: got busy=%b pulse=%b, expected 0 0", busy, pulse);
    end
    arst_n = 1'b1;
    tick();
  endtask

  task automatic test_legal_write();
    obs_t e, a;
    string n;
    int bc, pc;
    clear();
    do_txn(3'h2, 8'hA5, 1'b1, 2, bc, pc);
    push_exp("legal_write", 7'h00, 1'b0, 3'd0, 2'd1);
    e = exp_q.pop_front(); n = name_q.pop_front(); a = observe();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got err=%h vld=%b first=%0d cnt=%0d, expected err=%h vld=%b first=%0d cnt=%0d",
               n, a.err, a.vld, a.first, a.cnt, e.err, e.vld, e.first, e.cnt);
    end
    checks++;
    if (bc !== 2 || pc !== 0) begin
      errors++;
      $display("FAIL legal_busy_cycles: got busy=%0d pulses=%0d, expected busy=2 pulses=0", bc, pc);
    end
  endtask

  task automatic test_late_ack();
    obs_t e, a;
    string n;
    int bc, pc;
    clear();
    do_txn(3'h1, 8'h3C, 1'b0, 3, bc, pc);
    push_exp("late_ack", 7'h10, 1'b1, 3'd4, 2'd1);
    e = exp_q.pop_front(); n = name_q.pop_front(); a = observe();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got err=%h vld=%b first=%0d cnt=%0d, expected err=%h vld=%b first=%0d cnt=%0d",
               n, a.err, a.vld, a.first, a.cnt, e.err, e.vld, e.first, e.cnt);
    end
    checks++;
    if (pc !== 1 || bc !== 3) begin
      errors++;
      $display("FAIL late_pulse: got pulses=%0d busy=%0d, expected pulses=1 busy=3", pc, bc);
    end
  endtask

  task automatic test_zero_latency();
    obs_t e, a;
    string n;
    int bc, pc;
    clear();
    do_txn(3'h5, 8'h11, 1'b1, 0, bc, pc);
    push_exp("zero_lat_early", 7'h08, 1'b1, 3'd3, 2'd1);
    e = exp_q.pop_front(); n = name_q.pop_front(); a = observe();
    checks++;
    if (a !== e || bc !== 0) begin
      errors++;
      $display("FAIL %s: got err=%h vld=%b first=%0d cnt=%0d busy=%0d, expected err=%h vld=%b first=%0d cnt=%0d busy=0",
               n, a.err, a.vld, a.first, a.cnt, bc, e.err, e.vld, e.first, e.cnt);
    end
  endtask

  task automatic test_unstable_drop();
    obs_t e, a;
    string n;
    clear();
    adr = 3'h2; dat = 8'h00; we = 1'b0; cyc = 1'b1; stb = 1'b1; ack = 1'b0;
    tick();
    adr = 3'h3;
    tick();
    ack = 1'b1;
    tick();
    idle_bus();
    tick();
    push_exp("unstable", 7'h04, 1'b1, 3'd2, 2'd1);
    e = exp_q.pop_front(); n = name_q.pop_front(); a = observe();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got err=%h vld=%b first=%0d cnt=%0d, expected err=%h vld=%b first=%0d cnt=%0d",
               n, a.err, a.vld, a.first, a.cnt, e.err, e.vld, e.first, e.cnt);
    end
    cyc = 1'b1; stb = 1'b1;
    tick();
    stb = 1'b0;
    tick();
    idle_bus();
    tick();
    push_exp("drop", 7'h06, 1'b1, 3'd2, 2'd1);
    e = exp_q.pop_front(); n = name_q.pop_front(); a = observe();
    checks++;
    if (a !== e || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got err=%h vld=%b first=%0d cnt=%0d busy=%b, expected err=%h vld=%b first=%0d cnt=%0d busy=0",
               n, a.err, a.vld, a.first, a.cnt, busy, e.err, e.vld, e.first, e.cnt);
    end
  endtask

  task automatic test_timeout();
    obs_t e, a;
    string n;
    int  waited = 0;
    bit  done = 1'b0;
    clear();
    adr = 3'h4; dat = 8'h77; we = 1'b1; cyc = 1'b1; stb = 1'b1; ack = 1'b0;
    tick();
    while (!done && waited < 40) begin
      tick();
      waited++;
      if (!busy) done = 1'b1;
    end
    checks++;
    if (!done || waited !== 32) begin
      errors++;
      $display("FAIL timeout_cycles: got done=%b after %0d cycles, expected done=1 after 32", done, waited);
    end
    cyc = 1'b0; stb = 1'b0; ack = 1'b1;
    tick();
    idle_bus();
    tick();
    push_exp("timeout_then_spurious", 7'h21, 1'b1, 3'd5, 2'd0);
    e = exp_q.pop_front(); n = name_q.pop_front(); a = observe();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got err=%h vld=%b first=%0d cnt=%0d, expected err=%h vld=%b first=%0d cnt=%0d",
               n, a.err, a.vld, a.first, a.cnt, e.err, e.vld, e.first, e.cnt);
    end
  endtask

  task automatic test_ack_long_clear();
    obs_t e, a;
    string n;
    clear();
    adr = 3'h6; dat = 8'h5A; we = 1'b1; cyc = 1'b1; stb = 1'b1; ack = 1'b0;
    tick();
    ack = 1'b1;
    tick();
    cyc = 1'b0; stb = 1'b0;
    tick();
    push_exp("ack_long", 7'h40, 1'b1, 3'd6, 2'd1);
    e = exp_q.pop_front(); n = name_q.pop_front(); a = observe();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got err=%h vld=%b first=%0d cnt=%0d, expected err=%h vld=%b first=%0d cnt=%0d",
               n, a.err, a.vld, a.first, a.cnt, e.err, e.vld, e.first, e.cnt);
    end
    clr = 1'b1;
    tick();
    idle_bus();
    push_exp("clear_with_spurious", 7'h01, 1'b1, 3'd0, 2'd0);
    e = exp_q.pop_front(); n = name_q.pop_front(); a = observe();
    checks++;
    if (a !== e || pulse !== 1'b1) begin
      errors++;
      $display("FAIL %s: got err=%h vld=%b first=%0d cnt=%0d pulse=%b, expected err=%h vld=%b first=%0d cnt=%0d pulse=1",
               n, a.err, a.vld, a.first, a.cnt, pulse, e.err, e.vld, e.first, e.cnt);
    end
    tick();
  endtask

  task automatic test_saturation_and_reset();
    obs_t e, a;
    string n;
    int bc, pc;
    clear();
    for (int i = 0; i < 5; i++) begin
      do_txn(AW'(i), DW'(8'h10 + i), 1'b1, 2, bc, pc);
    end
    push_exp("cnt_saturate", 7'h00, 1'b0, 3'd0, 2'd3);
    e = exp_q.pop_front(); n = name_q.pop_front(); a = observe();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got err=%h vld=%b first=%0d cnt=%0d, expected err=%h vld=%b first=%0d cnt=%0d",
               n, a.err, a.vld, a.first, a.cnt, e.err, e.vld, e.first, e.cnt);
    end
    adr = 3'h1; dat = 8'hEE; we = 1'b1; cyc = 1'b1; stb = 1'b1; ack = 1'b0;
    tick();
    clr = 1'b0;
    ack = 1'b1; cyc = 1'b0; stb = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || err !== 7'h02) begin
      errors++;
      $display("FAIL drop_while_ack: got busy=%b err=%h, expected busy=0 err=02", busy, err);
    end
    idle_bus();
    tick();
    cyc = 1'b1; stb = 1'b1; ack = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_reset: got %b, expected 1", busy);
    end
    arst_n = 1'b0;
    #1;
    push_exp("async_reset_mid_wait", 7'h00, 1'b0, 3'd0, 2'd0);
    e = exp_q.pop_front(); n = name_q.pop_front(); a = observe();
    checks++;
    if (a !== e || busy !== 1'b0 || pulse !== 1'b0) begin
      errors++;
      $display("FAIL %s: got err=%h vld=%b first=%0d cnt=%0d busy=%b pulse=%b, expected all 0",
               n, a.err, a.vld, a.first, a.cnt, busy, pulse);
    end
    idle_bus();
    #1;
    arst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_legal_write();
    test_late_ack();
    test_zero_latency();
    test_unstable_drop();
    test_timeout();
    test_ack_long_clear();
    test_saturation_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
